stream_sink_acc: RTL
====================

STREAM_SINK_ACC -- requirements
Module: stream_sink_acc

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: width of each incoming data word.
REQ-002 SHALL have parameter PACKET_LEN, default 4: words per packet; legal range 2..256.
REQ-003 SHALL have parameter THROTTLE_PERIOD, default 4: ready_out throttle period in cycles; legal range 2..256.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_in  input  DATA_SIZE  stream word from the upstream FIFO.
REQ-007 SHALL have port valid_in  input  1  data_in holds a valid word.
REQ-008 SHALL have port ready_out  output  1  sink can accept a word; drives the upstream fifo_out_ready.
REQ-009 SHALL have port throttle_en  input  1  enables periodic ready_out deassertion.
REQ-010 SHALL have port sum_out  output  SUM_W  sum of the last completed packet, where SUM_W = DATA_SIZE + clog2(PACKET_LEN).
REQ-011 SHALL have port sum_valid  output  1  one-cycle pulse: sum_out is new.
REQ-012 SHALL have port packet_count  output  16  number of completed packets; wraps from 0xFFFF to 0.

Function
REQ-013 A transfer SHALL occur exactly on a rising edge where valid_in && ready_out; no other cycle consumes data.
REQ-014 The FSM SHALL have two states: COLLECT and EMIT.
REQ-015 COLLECT: on each transfer, acc += data_in (zero-extended to SUM_W) and word_cnt += 1.
REQ-016 COLLECT -> EMIT on the transfer that makes word_cnt reach PACKET_LEN; on that same edge sum_out SHALL load acc + data_in.
REQ-017 EMIT: sum_valid = 1 and ready_out = 0 for exactly one cycle, then unconditional EMIT -> COLLECT with acc = 0 and word_cnt = 0.
REQ-018 packet_count SHALL increment on the COLLECT -> EMIT edge.
REQ-019 sum_out SHALL hold its value until the next packet completes.
REQ-020 Throttle counter thr_cnt SHALL run freely, 0..THROTTLE_PERIOD-1, wrapping to 0, independent of FSM state.
REQ-021 ready_out = (state == COLLECT) && !(throttle_en && thr_cnt == THROTTLE_PERIOD-1); ready_out SHALL be a combinational decode of registered state only and SHALL NOT depend on valid_in.
REQ-022 A valid_in gap mid-packet SHALL NOT alter acc or word_cnt; accumulation resumes on the next transfer.
REQ-023 Sum arithmetic SHALL be unsigned and SHALL NOT overflow: PACKET_LEN*(2^DATA_SIZE-1) fits in SUM_W.
REQ-024 Steady-state throughput with valid_in held high and throttle_en = 0 SHALL be PACKET_LEN words per PACKET_LEN+1 cycles.
REQ-025 Latency SHALL be one cycle: sum_valid is high in the cycle after the last word's transfer edge.

Reset
REQ-026 While reset is high at a rising edge, state SHALL go to COLLECT and acc, word_cnt, thr_cnt, sum_out and packet_count SHALL go to 0.
REQ-027 After reset, sum_valid SHALL be 0 and ready_out SHALL be 1.
REQ-028 Reset asserted mid-packet or during EMIT SHALL discard the partial packet with no sum_valid pulse.
REQ-029 Reset SHALL take priority over a simultaneous transfer.

Structure
REQ-030 FSM state encodings (COLLECT = 1'b0, EMIT = 1'b1) and the SUM_W derivation SHALL live in the shared stream definitions header, reused by the pipeline top.
REQ-031 The throttle counter and its decode SHALL be one sub-module, ready_throttle, with parameter THROTTLE_PERIOD, inputs clk, reset, throttle_en and output 1-bit hold_off.
REQ-032 All remaining logic SHALL be flat in stream_sink_acc; there SHALL be no internal FIFO or storage beyond the accumulator.

Verification
REQ-033 Reset for 2 cycles, then data_in = 1 with valid_in = 1 continuously, throttle_en = 0 -> sum_valid pulses every 5 cycles with sum_out = 4; packet_count = 1, 2, 3...
REQ-034 Words 255, 255, 255, 255 -> sum_out = 1020 (10'h3FC) with no truncation.
REQ-035 data_in = 1 with valid_in toggling 1,0,1,0... -> sum_out = 4 after the 4th transfer; acc unchanged during gap cycles.
REQ-036 throttle_en = 1, THROTTLE_PERIOD = 4, valid_in = 1 -> ready_out low every 4th cycle and in EMIT; sum_out still = 4 for data_in = 1.
REQ-037 Reset asserted after 2 transfers of data_in = 1 -> no sum_valid; the next 4 transfers give sum_out = 4, not 6.
REQ-038 Force packet_count to 0xFFFF, then complete one packet -> packet_count = 0 and sum_valid pulses normally.

Source files
------------

// File: rtl/stream_sink_acc_pkg.sv
// Shared stream definitions: FSM state encodings and sum-width derivation.
// Used by stream_sink_acc and any pipeline top that consumes its sum_out.
package stream_sink_acc_pkg;

    // Sink FSM state encodings
    localparam logic STATE_COLLECT = 1'b0;
    localparam logic STATE_EMIT    = 1'b1;

    // Width that holds PACKET_LEN * (2^DATA_SIZE - 1) without overflow
    function automatic int unsigned sum_width(input int unsigned data_size,
                                              input int unsigned packet_len);
        return data_size + int'($clog2(packet_len));
    endfunction

endpackage

// File: rtl/stream_sink_acc_ready_throttle.sv
// ready_throttle: free-running counter 0..THROTTLE_PERIOD-1 whose last count
// requests a one-cycle ready deassertion when throttling is enabled.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   throttle_en : enables the periodic hold-off
//   hold_off    : high in the last count of each period while throttle_en
module ready_throttle #(
    parameter int unsigned THROTTLE_PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic throttle_en,
    output logic hold_off
);

    localparam int unsigned CW = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
    localparam logic [CW-1:0] THR_LAST = CW'(THROTTLE_PERIOD - 1);

    logic [CW-1:0] thr_cnt_q;
    logic [CW-1:0] thr_cnt_d;

    // Counter wraps independently of throttle_en and of the sink FSM
    always_comb begin
        thr_cnt_d = thr_cnt_q + CW'(1);
        if (thr_cnt_q == THR_LAST) begin
            thr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_cnt_q <= '0;
        end else begin
            thr_cnt_q <= thr_cnt_d;
        end
    end

    assign hold_off = throttle_en && (thr_cnt_q == THR_LAST);

endmodule

// File: rtl/stream_sink_acc.sv
// stream_sink_acc: stream sink that sums fixed-length packets of words.
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   data_in      : stream word from the upstream FIFO
//   valid_in     : data_in holds a valid word
//   ready_out    : sink can accept a word (decode of registered state only)
//   throttle_en  : enables periodic ready_out deassertion
//   sum_out      : sum of the last completed packet, held until the next one
//   sum_valid    : one-cycle pulse when sum_out is new
//   packet_count : completed packets, wraps at 16 bits
module stream_sink_acc
    import stream_sink_acc_pkg::*;
#(
    parameter  int unsigned DATA_SIZE       = 8,
    parameter  int unsigned PACKET_LEN      = 4,
    parameter  int unsigned THROTTLE_PERIOD = 4,
    localparam int unsigned SUM_W           = sum_width(DATA_SIZE, PACKET_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 throttle_en,
    output logic [SUM_W-1:0]     sum_out,
    output logic                 sum_valid,
    output logic [15:0]          packet_count
);

    localparam int unsigned CNT_W = $clog2(PACKET_LEN);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PACKET_LEN - 1);

    logic             state_q,        state_d;
    logic [SUM_W-1:0] acc_q,          acc_d;
    logic [CNT_W-1:0] word_cnt_q,     word_cnt_d;
    logic [SUM_W-1:0] sum_q,          sum_d;
    logic [15:0]      packet_count_q, packet_count_d;

    logic hold_off;
    logic transfer_c;
    logic [SUM_W-1:0] acc_plus_c;

    ready_throttle #(
        .THROTTLE_PERIOD (THROTTLE_PERIOD)
    ) u_ready_throttle (
        .clk         (clk),
        .reset       (reset),
        .throttle_en (throttle_en),
        .hold_off    (hold_off)
    );

    assign ready_out  = (state_q == STATE_COLLECT) && !hold_off;
    assign transfer_c = valid_in && ready_out;
    assign acc_plus_c = acc_q + SUM_W'(data_in);

    // Next-state: accumulate in COLLECT, publish on the last word, clear after EMIT
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        word_cnt_d     = word_cnt_q;
        sum_d          = sum_q;
        packet_count_d = packet_count_q;
        case (state_q)
            STATE_COLLECT: begin
                if (transfer_c) begin
                    acc_d      = acc_plus_c;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (word_cnt_q == LAST_WORD) begin
                        state_d        = STATE_EMIT;
                        sum_d          = acc_plus_c;
                        packet_count_d = packet_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d    = STATE_COLLECT;
                acc_d      = '0;
                word_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= STATE_COLLECT;
            acc_q          <= '0;
            word_cnt_q     <= '0;
            sum_q          <= '0;
            packet_count_q <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            word_cnt_q     <= word_cnt_d;
            sum_q          <= sum_d;
            packet_count_q <= packet_count_d;
        end
    end

    assign sum_out      = sum_q;
    assign sum_valid    = (state_q == STATE_EMIT);
    assign packet_count = packet_count_q;

endmodule
